// File: rtl/mips_ctrl_decode_pkg.sv
// Shared opcode/funct encodings, ALU codes and control bundle for the MIPS decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function field, instruction bits [5:0]
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_XNOR  = 6'b100111; // NOR slot, executed as XNOR by this ALU
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU operation codes; 1011..1111 are unused
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_XNOR = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    // Writeback source select
    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

    // Full control word, registered as one bundle in the top
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       jump;
        logic       start_mult;
        logic       signed_mult;
        logic [1:0] mf_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mips_ctrl_decode_if.sv
// Instruction-field inputs and datapath control outputs of the main decoder.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are plain levels.
interface mips_ctrl_decode_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic [3:0] ALUControl;
    logic       ALUSrc;
    logic       RegDst;
    logic       branch;
    logic       jump;
    logic       startMult;
    logic       signedMult;
    logic [1:0] mfReg;

    // Instruction register side: drives fields, observes decoded controls
    modport master (
        output op, funct,
        input  RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst,
               branch, jump, startMult, signedMult, mfReg
    );

    // Decoder side
    modport slave (
        input  op, funct,
        output RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst,
               branch, jump, startMult, signedMult, mfReg
    );

endinterface

// File: rtl/mips_ctrl_decode_alu.sv
// Combinational op/funct to ALUControl map.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctrl
);

    // Non-ALU instructions (j, mfhi/mflo, mult, illegal) fall through to AND (0000)
    always_comb begin
        o_alu_ctrl = ALU_AND;
        if (i_op == OP_RTYPE) begin
            case (i_funct)
                FN_ADD:  o_alu_ctrl = ALU_ADD;
                FN_ADDU: o_alu_ctrl = ALU_ADDU;
                FN_SUB:  o_alu_ctrl = ALU_SUB;
                FN_SUBU: o_alu_ctrl = ALU_SUBU;
                FN_AND:  o_alu_ctrl = ALU_AND;
                FN_OR:   o_alu_ctrl = ALU_OR;
                FN_XOR:  o_alu_ctrl = ALU_XOR;
                FN_XNOR: o_alu_ctrl = ALU_XNOR;
                FN_SLT:  o_alu_ctrl = ALU_SLT;
                FN_SLTU: o_alu_ctrl = ALU_SLTU;
                default: o_alu_ctrl = ALU_AND;
            endcase
        end else begin
            case (i_op)
                OP_LW, OP_SW:   o_alu_ctrl = ALU_ADD;
                OP_BEQ, OP_BNE: o_alu_ctrl = ALU_SUB;
                OP_ADDI:        o_alu_ctrl = ALU_ADD;
                OP_ADDIU:       o_alu_ctrl = ALU_ADDU;
                OP_ANDI:        o_alu_ctrl = ALU_AND;
                OP_ORI:         o_alu_ctrl = ALU_OR;
                OP_XORI:        o_alu_ctrl = ALU_XOR;
                OP_SLTI:        o_alu_ctrl = ALU_SLT;
                OP_SLTIU:       o_alu_ctrl = ALU_SLTU;
                OP_LUI:         o_alu_ctrl = ALU_LUI;
                default:        o_alu_ctrl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/mips_ctrl_decode.sv
// Main MIPS control decoder: op/funct to registered datapath controls.
// Latency: 1 cycle from op/funct to outputs; reset zeroes outputs asynchronously.
// Backpressure: none; a new decode is loaded every clock.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    mips_ctrl_decode_if.slave  bus
);

    logic [3:0] w_alu_ctrl;
    ctrl_t      w_ctrl;
    ctrl_t      r_ctrl;

    mips_alu_decode u_alu_decode (
        .i_op       (bus.op),
        .i_funct    (bus.funct),
        .o_alu_ctrl (w_alu_ctrl)
    );

    // Main decode: anything unrecognised leaves the NOP word untouched
    always_comb begin
        w_ctrl = CTRL_NOP;
        if (bus.op == OP_RTYPE) begin
            case (bus.funct)
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
                FN_OR, FN_XOR, FN_XNOR, FN_SLT, FN_SLTU: begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.reg_dst   = 1'b1;
                    w_ctrl.alu_ctrl  = w_alu_ctrl;
                end
                FN_MFHI: begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.reg_dst   = 1'b1;
                    w_ctrl.mf_reg    = MF_HI;
                end
                FN_MFLO: begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.reg_dst   = 1'b1;
                    w_ctrl.mf_reg    = MF_LO;
                end
                FN_MULT: begin
                    w_ctrl.start_mult  = 1'b1;
                    w_ctrl.signed_mult = 1'b1;
                end
                FN_MULTU: begin
                    w_ctrl.start_mult  = 1'b1;
                end
                default: w_ctrl = CTRL_NOP;
            endcase
        end else begin
            case (bus.op)
                OP_LW: begin
                    w_ctrl.reg_write  = 1'b1;
                    w_ctrl.alu_src    = 1'b1;
                    w_ctrl.mem_to_reg = 1'b1;
                    w_ctrl.alu_ctrl   = w_alu_ctrl;
                end
                OP_SW: begin
                    w_ctrl.mem_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.alu_ctrl  = w_alu_ctrl;
                end
                OP_BEQ, OP_BNE: begin
                    w_ctrl.branch   = 1'b1;
                    w_ctrl.alu_ctrl = w_alu_ctrl;
                end
                OP_J: begin
                    w_ctrl.jump = 1'b1;
                end
                OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.alu_ctrl  = w_alu_ctrl;
                end
                default: w_ctrl = CTRL_NOP;
            endcase
        end
    end

    // Output register bank; reset is a full NOP so pending writes/branches are cancelled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= CTRL_NOP;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign bus.RegWrite   = r_ctrl.reg_write;
    assign bus.MemtoReg   = r_ctrl.mem_to_reg;
    assign bus.MemWrite   = r_ctrl.mem_write;
    assign bus.ALUControl = r_ctrl.alu_ctrl;
    assign bus.ALUSrc     = r_ctrl.alu_src;
    assign bus.RegDst     = r_ctrl.reg_dst;
    assign bus.branch     = r_ctrl.branch;
    assign bus.jump       = r_ctrl.jump;
    assign bus.startMult  = r_ctrl.start_mult;
    assign bus.signedMult = r_ctrl.signed_mult;
    assign bus.mfReg      = r_ctrl.mf_reg;

endmodule

// File: tb/tb_mips_ctrl_decode.sv
// Randomised scoreboard bench for mips_ctrl_decode against a table-driven reference model.
// Latency: expectations are checked one clock after the instruction is presented.
// Backpressure: none; one instruction per cycle.
module tb_mips_ctrl_decode;

    logic clk;
    logic reset_n;

    mips_ctrl_decode_if bus ();

    mips_ctrl_decode dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] v;
        logic [5:0]  op;
        logic [5:0]  funct;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference tables: ALU code of each R-type ALU funct and each immediate opcode
    logic [3:0] rt_alu  [64];
    bit         rt_ok   [64];
    logic [3:0] imm_alu [64];
    bit         imm_ok  [64];

    logic [5:0] legal_ops [14] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10,
                                   6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};

    // Output order: RegWrite MemtoReg MemWrite ALUControl ALUSrc RegDst branch jump startMult signedMult mfReg
    function automatic logic [14:0] dut_vec();
        return {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.ALUControl, bus.ALUSrc,
                bus.RegDst, bus.branch, bus.jump, bus.startMult, bus.signedMult, bus.mfReg};
    endfunction

    function automatic logic [14:0] model(input logic [5:0] o, input logic [5:0] f);
        logic       rw, mtr, mw, src, dst, br, j, sm, sg;
        logic [3:0] alu;
        logic [1:0] mf;
        rw = 0; mtr = 0; mw = 0; src = 0; dst = 0; br = 0; j = 0; sm = 0; sg = 0;
        alu = 4'd0; mf = 2'd0;
        if (o == 6'd0) begin
            if (rt_ok[f]) begin rw = 1; dst = 1; alu = rt_alu[f]; end
            else if (f == 6'd16) begin rw = 1; dst = 1; mf = 2'd1; end
            else if (f == 6'd18) begin rw = 1; dst = 1; mf = 2'd2; end
            else if (f == 6'd24) begin sm = 1; sg = 1; end
            else if (f == 6'd25) begin sm = 1; end
        end else if (o == 6'd35) begin rw = 1; src = 1; mtr = 1; alu = 4'd2; end
        else if (o == 6'd43) begin mw = 1; src = 1; alu = 4'd2; end
        else if (o == 6'd4 || o == 6'd5) begin br = 1; alu = 4'd6; end
        else if (o == 6'd2) begin j = 1; end
        else if (imm_ok[o]) begin rw = 1; src = 1; alu = imm_alu[o]; end
        return {rw, mtr, mw, alu, src, dst, br, j, sm, sg, mf};
    endfunction

    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        @(negedge clk);
        bus.op    = o;
        bus.funct = f;
        e.v = model(o, f); e.op = o; e.funct = f;
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        logic [14:0] got;
        got = dut_vec();
        total++;
        if (got !== 15'd0) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, 15'd0);
        end
    endtask

    // Asynchronous reset pulse straddling one clock edge
    task automatic pulse_reset(input string name);
        @(negedge clk);
        reset_n = 1'b0;
        #1 check_zero({name, "_async"});
        @(posedge clk);
        #1 check_zero({name, "_hold"});
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one registered decode per clock, compared against the oldest expectation
    initial begin
        exp_t        e;
        logic [14:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = dut_vec();
                total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL decode op=%b funct=%b got=%b exp=%b", e.op, e.funct, got, e.v);
                end
            end
        end
    end

    initial begin
        logic [5:0] o, f;
        int         pick;

        rt_alu[32] = 4'd2; rt_alu[33] = 4'd3; rt_alu[34] = 4'd6; rt_alu[35] = 4'd7;
        rt_alu[36] = 4'd0; rt_alu[37] = 4'd1; rt_alu[38] = 4'd4; rt_alu[39] = 4'd5;
        rt_alu[42] = 4'd8; rt_alu[43] = 4'd9;
        foreach (rt_ok[i]) rt_ok[i] = (i >= 32 && i <= 39) || i == 42 || i == 43;
        imm_alu[8]  = 4'd2; imm_alu[9]  = 4'd3; imm_alu[12] = 4'd0; imm_alu[13] = 4'd1;
        imm_alu[14] = 4'd4; imm_alu[10] = 4'd8; imm_alu[11] = 4'd9; imm_alu[15] = 4'd10;
        foreach (imm_ok[i]) imm_ok[i] = (i >= 8 && i <= 15);

        reset_n   = 1'b1;
        bus.op    = 6'b100011;
        bus.funct = 6'd0;

        // Load a non-zero decode (lw), then reset must clear it without a clock edge
        issue(6'b100011, 6'd0);
        pulse_reset("reset_lw");
        issue(6'b100011, 6'd0);

        // R-type ALU sweep
        for (int i = 32; i <= 43; i++) issue(6'd0, 6'(i));
        // HI/LO moves and multiplies
        issue(6'd0, 6'b010000);
        issue(6'd0, 6'b010010);
        issue(6'd0, 6'b011000);
        issue(6'd0, 6'b011001);
        issue(6'd0, 6'b011000); // back-to-back mult keeps startMult high
        // Memory and control flow
        issue(6'b101011, 6'd0);
        issue(6'b000100, 6'd0);
        issue(6'b000101, 6'b100000);
        issue(6'b000010, 6'd0);
        // Immediates, with junk funct that must be ignored
        for (int i = 8; i <= 15; i++) issue(6'(i), 6'($urandom));
        // Illegal encodings
        issue(6'b111111, 6'd0);
        issue(6'd0, 6'b111111);

        // Random traffic with a reset pulse mid-stream
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                issue(6'b000100, 6'd0);
                pulse_reset("reset_mid");
            end
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       begin o = 6'd0; f = 6'($urandom); end
                1:       begin o = 6'd0; f = 6'($urandom_range(32, 43)); end
                2:       begin o = legal_ops[$urandom_range(0, 13)]; f = 6'($urandom); end
                default: begin o = 6'($urandom); f = 6'($urandom); end
            endcase
            issue(o, f);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_decode.md
Name: mips_ctrl_decode

Overview:
- Main control decoder for the single-issue MIPS datapath.
- Decodes the instruction opcode (op) and R-type function field (funct) into datapath control signals: register-file write, memory, ALU operation, branch/jump, multiplier start and HI/LO move select.
- Decode is combinational internally; all outputs are registered (one-cycle latency).
- Sits between the instruction register and the datapath/multiplier.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- op  input  6  instruction opcode [31:26]
- funct  input  6  R-type function field [5:0]
- RegWrite  output  1  register file write enable
- MemtoReg  output  1  1 = writeback from data memory, 0 = from ALU/HI/LO
- MemWrite  output  1  data memory write enable
- ALUControl  output  4  ALU operation code
- ALUSrc  output  1  1 = immediate operand, 0 = rt
- RegDst  output  1  1 = write rd, 0 = write rt
- branch  output  1  conditional branch; datapath uses op[0] (0 = beq, 1 = bne)
- jump  output  1  unconditional jump
- startMult  output  1  start multiplier
- signedMult  output  1  1 = signed multiply
- mfReg  output  2  writeback source: 00 ALU/mem, 01 HI, 10 LO

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - reset_n = 0 forces every output to 0 immediately.
  - This is a full NOP, so asserting reset mid-operation cancels any pending write, branch or jump.
- Latency: on each rising clk, outputs load the decode of the current op/funct. Latency is 1 cycle; there is no handshake.
- Default: any signal not listed for an instruction is 0.
- ALUControl codes: AND 0000, OR 0001, ADD 0010, ADDU 0011, XOR 0100, XNOR 0101, SUB 0110, SUBU 0111, SLT 1000, SLTU 1001, LUI 1010. Codes 1011–1111 are never produced.
- R-type (op 000000):
  - ALU ops set RegWrite = 1, RegDst = 1.
  - funct→ALU: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 XNOR (NOR encoding), 101010 SLT, 101011 SLTU.
  - mfhi 010000: RegWrite = 1, RegDst = 1, mfReg = 01, ALUControl = 0000.
  - mflo 010010: RegWrite = 1, RegDst = 1, mfReg = 10, ALUControl = 0000.
  - mult 011000: startMult = 1, signedMult = 1, RegWrite = 0.
  - multu 011001: startMult = 1, signedMult = 0, RegWrite = 0.
  - Unlisted funct: all outputs 0.
- I/J-type:
  - lw 100011: RegWrite = 1, ALUSrc = 1, MemtoReg = 1, ADD.
  - sw 101011: MemWrite = 1, ALUSrc = 1, ADD.
  - beq 000100 and bne 000101: branch = 1, SUB.
  - j 000010: jump = 1.
  - ALUSrc = 1, RegWrite = 1, RegDst = 0 with: addi 001000 ADD, addiu 001001 ADDU, andi 001100 AND, ori 001101 OR, xori 001110 XOR, slti 001010 SLT, sltiu 001011 SLTU, lui 001111 LUI.
  - funct is ignored for non-zero op.
  - Unlisted op: all outputs 0.
- Level semantics: startMult is a level, held high every cycle a mult/multu is presented. The multiplier owns edge detection.
- Exclusivity invariants: MemWrite, branch and jump are never simultaneously 1 with RegWrite. mfReg ≠ 00 only for mfhi/mflo.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams (OP_RTYPE, OP_LW, …, FN_ADD, …);
  - ALUControl code constants;
  - mfReg constants (MF_NONE, MF_HI, MF_LO).
- One natural sub-module: mips_alu_decode, a combinational funct/op→ALUControl map.
- The main decode plus the output register bank stays in the top.

Test Plan:
- Reset: reset_n = 0 with op = 100011 → all outputs 0 without a clock edge. Release, one clk → RegWrite = 1, ALUSrc = 1, MemtoReg = 1, ALUControl = 0010.
- R-type sweep: op = 0; funct 100000, 100001, 100010, 100011, 100100, 100101, 100110, 100111, 101010, 101011 → ALUControl 0010, 0011, 0110, 0111, 0000, 0001, 0100, 0101, 1000, 1001, each with RegWrite = 1, RegDst = 1, one cycle after the input.
- HI/LO and multiply:
  - mfhi → mfReg = 01, RegWrite = 1.
  - mflo → mfReg = 10, RegWrite = 1.
  - mult → startMult = 1, signedMult = 1, RegWrite = 0.
  - multu → startMult = 1, signedMult = 0.
- Memory/control flow:
  - sw → MemWrite = 1, RegWrite = 0, ADD.
  - beq and bne → branch = 1, ALUControl = 0110.
  - j → jump = 1, everything else 0.
- Immediates: addi/addiu/andi/ori/xori/slti/sltiu/lui → ALUSrc = 1, RegWrite = 1, RegDst = 0, ALUControl 0010/0011/0000/0001/0100/1000/1001/1010.
- Illegal: op = 111111, and op = 0 with funct = 111111 → all outputs 0. A mid-stream reset pulse zeroes outputs asynchronously.
